// File: rtl/rs_err_info_pipe.sv
// Two-stage RS(DATA_SYMS+2) single-symbol error locator over GF(2^8) with valid/ready handshakes.
// Optional statistics counters are built when RS_ERR_INFO_STATS_EN is defined.
module rs_err_info_pipe #(
  parameter  int DATA_SYMS = 8,
  parameter  int CNT_W     = 16,
  localparam int LOC_W     = $clog2(DATA_SYMS + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      syndrome_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOC_W-1:0] err_loc_out,
  output logic [7:0]       err_val_out,
  output logic [1:0]       result_out,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ce_cnt,
  output logic [CNT_W-1:0] due_cnt
);

  localparam logic [7:0]       DS8     = 8'(DATA_SYMS);
  localparam logic [LOC_W-1:0] LOC_P0  = LOC_W'(DATA_SYMS);
  localparam logic [LOC_W-1:0] LOC_P1  = LOC_W'(DATA_SYMS + 1);
  localparam logic [1:0]       RES_NE  = 2'b00;
  localparam logic [1:0]       RES_CE  = 2'b01;
  localparam logic [1:0]       RES_DUE = 2'b10;

  // Discrete log over x^8+x^4+x^3+x^2+1; the loop unrolls into a pure lookup.
  function automatic logic [7:0] gf_log(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = 8'h01;
    r = 8'h00;
    for (int i = 0; i < 255; i++) begin
      if (p == x) r = 8'(i);
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1D : 8'h00);
    end
    return r;
  endfunction

  logic             st1_valid;
  logic [7:0]       st1_s0;
  logic [7:0]       st1_s1;
  logic             st1_z0;
  logic             st1_z1;
  logic [7:0]       st1_log0;
  logic [7:0]       st1_log1;
  logic             adv2;
  logic [8:0]       diff9;
  logic [7:0]       diff;
  logic [LOC_W-1:0] nxt_loc;
  logic [7:0]       nxt_val;
  logic [1:0]       nxt_res;

  assign adv2     = !out_valid || out_ready;
  assign in_ready = !st1_valid || adv2;

  // Stage 1: capture syndromes, zero flags and their logs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st1_valid <= 1'b0;
      st1_s0    <= 8'h00;
      st1_s1    <= 8'h00;
      st1_z0    <= 1'b0;
      st1_z1    <= 1'b0;
      st1_log0  <= 8'h00;
      st1_log1  <= 8'h00;
    end else if (in_ready) begin
      st1_valid <= in_valid;
      if (in_valid) begin
        st1_s0   <= syndrome_in[15:8];
        st1_s1   <= syndrome_in[7:0];
        st1_z0   <= (syndrome_in[15:8] == 8'h00);
        st1_z1   <= (syndrome_in[7:0] == 8'h00);
        st1_log0 <= gf_log(syndrome_in[15:8]);
        st1_log1 <= gf_log(syndrome_in[7:0]);
      end
    end
  end

  // Locator = log(S1)-log(S0) mod 255, then classify the word.
  always_comb begin
    diff9   = {1'b0, st1_log1} - {1'b0, st1_log0};
    nxt_loc = '0;
    nxt_val = 8'h00;
    nxt_res = RES_NE;
    if (st1_log1 < st1_log0) begin
      diff9 = diff9 + 9'd255;
    end else begin
      diff9 = diff9;
    end
    diff = diff9[7:0];
    if (st1_valid) begin
      case ({st1_z0, st1_z1})
        2'b11: begin
          nxt_res = RES_NE;
        end
        2'b01: begin
          nxt_res = RES_CE;
          nxt_loc = LOC_P0;
          nxt_val = st1_s0;
        end
        2'b10: begin
          nxt_res = RES_CE;
          nxt_loc = LOC_P1;
          nxt_val = st1_s1;
        end
        2'b00: begin
          if (diff < DS8) begin
            nxt_res = RES_CE;
            nxt_loc = LOC_W'(diff);
            nxt_val = st1_s0;
          end else begin
            nxt_res = RES_DUE;
          end
        end
        default: begin
          nxt_res = RES_NE;
        end
      endcase
    end else begin
      nxt_res = RES_NE;
    end
  end

  // Stage 2: result registers, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      err_loc_out <= '0;
      err_val_out <= 8'h00;
      result_out  <= RES_NE;
    end else if (adv2) begin
      out_valid   <= st1_valid;
      err_loc_out <= nxt_loc;
      err_val_out <= nxt_val;
      result_out  <= nxt_res;
    end
  end

`ifdef RS_ERR_INFO_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic out_hs;
  logic [CNT_W-1:0] ce_q;
  logic [CNT_W-1:0] due_q;

  assign out_hs = out_valid && out_ready;

  // Saturating CE/DUE counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      ce_q  <= '0;
      due_q <= '0;
    end else if (out_hs) begin
      if (result_out == RES_CE && ce_q != CNT_MAX) ce_q <= ce_q + CNT_ONE;
      if (result_out == RES_DUE && due_q != CNT_MAX) due_q <= due_q + CNT_ONE;
    end
  end

  assign ce_cnt  = ce_q;
  assign due_cnt = due_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign ce_cnt  = '0;
  assign due_cnt = '0;
`endif

endmodule

// File: tb/tb_rs_err_info_pipe.sv
// Directed, table-driven bench for rs_err_info_pipe (DATA_SYMS=8, CNT_W=4).
module tb_rs_err_info_pipe;

  typedef struct {
    logic [15:0] sy;
    logic [1:0]  res;
    logic [3:0]  loc;
    logic [7:0]  val;
  } vec_t;

`ifdef RS_ERR_INFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [15:0] syndrome_in;
  logic [3:0]  err_loc_out;
  logic [7:0]  err_val_out;
  logic [1:0]  result_out;
  logic [3:0]  ce_cnt, due_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ce   = 0;
  int exp_due  = 0;
  vec_t tbl[10];
  vec_t q[$];
  bit blocked;

  rs_err_info_pipe #(.DATA_SYMS(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .syndrome_in(syndrome_in), .out_valid(out_valid), .out_ready(out_ready),
    .err_loc_out(err_loc_out), .err_val_out(err_val_out), .result_out(result_out),
    .cnt_clr(cnt_clr), .ce_cnt(ce_cnt), .due_cnt(due_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_out(input logic [1:0] res, input logic clr);
    if (clr) begin
      exp_ce  = 0;
      exp_due = 0;
    end else if (STATS && res == 2'b01) begin
      exp_ce = (exp_ce < 15) ? exp_ce + 1 : 15;
    end else if (STATS && res == 2'b10) begin
      exp_due = (exp_due < 15) ? exp_due + 1 : 15;
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_ce_cnt"}, 32'(ce_cnt), 32'(exp_ce));
    chk({tag, "_due_cnt"}, 32'(due_cnt), 32'(exp_due));
  endtask

  // Streams q through the DUT with out_ready low on cycles stall_lo..stall_hi.
  task automatic stream(input int n, input int stall_lo, input int stall_hi,
                        input int clr_at, output bit saw_block);
    int sent, got;
    bit stalled;
    logic [3:0] h_loc;
    logic [7:0] h_val;
    logic [1:0] h_res;
    sent = 0; got = 0; stalled = 1'b0; saw_block = 1'b0;
    h_loc = 4'd0; h_val = 8'h00; h_res = 2'b00;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      in_valid    = (sent < n);
      syndrome_in = (sent < n) ? q[sent].sy : 16'h0000;
      out_ready   = !(c >= stall_lo && c <= stall_hi);
      cnt_clr     = (c == clr_at);
      #1;
      if (stalled) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_loc", 32'(err_loc_out), 32'(h_loc));
        chk("hold_val", 32'(err_val_out), 32'(h_val));
        chk("hold_res", 32'(result_out), 32'(h_res));
      end
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (out_valid && out_ready) begin
        chk("strm_res", 32'(result_out), 32'(q[got].res));
        chk("strm_loc", 32'(err_loc_out), 32'(q[got].loc));
        chk("strm_val", 32'(err_val_out), 32'(q[got].val));
        model_out(result_out, cnt_clr);
        got++;
      end else if (cnt_clr) begin
        model_out(2'b00, 1'b1);
      end
      stalled = out_valid && !out_ready;
      h_loc = err_loc_out; h_val = err_val_out; h_res = result_out;
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    #1;
    chk("strm_count", 32'(got), 32'(n));
    chk("strm_drained", 32'(out_valid), 32'd0);
  endtask

  initial begin
    tbl = '{
      '{16'h0108, 2'b01, 4'd3, 8'h01},
      '{16'h5A5A, 2'b01, 4'd0, 8'h5A},
      '{16'h3700, 2'b01, 4'd8, 8'h37},
      '{16'h0042, 2'b01, 4'd9, 8'h42},
      '{16'h0000, 2'b00, 4'd0, 8'h00},
      '{16'h011D, 2'b10, 4'd0, 8'h00},
      '{16'h8E01, 2'b01, 4'd1, 8'h8E},
      '{16'h0180, 2'b01, 4'd7, 8'h01},
      '{16'h0201, 2'b10, 4'd0, 8'h00},
      '{16'hFFFF, 2'b01, 4'd0, 8'hFF}
    };
    rst = 1'b1; in_valid = 1'b1; syndrome_in = 16'h0108; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_loc", 32'(err_loc_out), 32'd0);
    chk("rst_val", 32'(err_val_out), 32'd0);
    chk("rst_res", 32'(result_out), 32'd0);
    chk_cnt("rst");
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #1;
    chk("rst_no_stale", 32'(out_valid), 32'd0);

    // Single words: exact 2-cycle latency and classification.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; syndrome_in = tbl[i].sy; out_ready = 1'b1;
      #1;
      chk("tbl_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("tbl_lat1", 32'(out_valid), 32'd0);
      chk_cnt("tbl");
      @(negedge clk);
      #1;
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_res", 32'(result_out), 32'(tbl[i].res));
      chk("tbl_loc", 32'(err_loc_out), 32'(tbl[i].loc));
      chk("tbl_val", 32'(err_val_out), 32'(tbl[i].val));
      model_out(result_out, 1'b0);
    end
    @(negedge clk);
    #1;
    chk_cnt("tbl_end");

    // Back-to-back 4 words with downstream stalled on cycles 2..5.
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(tbl[i]);
    q.push_back(tbl[5]);
    stream(4, 2, 5, -1, blocked);
    chk("bp_in_ready_dropped", 32'(blocked), 32'd1);
    chk_cnt("bp");

    // 20 CE words to saturate the 4-bit counter.
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(tbl[0]);
    stream(20, 1000, 1000, -1, blocked);
    chk_cnt("sat");
    chk("sat_ce_15", 32'(ce_cnt), STATS ? 32'd15 : 32'd0);

    // Clear coincident with a CE output handshake.
    q.delete();
    q.push_back(tbl[0]);
    stream(1, 1000, 1000, 2, blocked);
    chk_cnt("clr");

    // DUE after clear: due_cnt 0 -> 1.
    q.delete();
    q.push_back(tbl[5]);
    stream(1, 1000, 1000, -1, blocked);
    chk_cnt("due");

    // Reset while the pipeline is full and stalled.
    @(negedge clk);
    in_valid = 1'b1; syndrome_in = 16'h0108; out_ready = 1'b0;
    @(negedge clk);
    syndrome_in = 16'h3700;
    @(negedge clk);
    #1;
    chk("mid_full_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    model_out(2'b00, 1'b1);
    chk_cnt("mid_rst");
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("mid_no_stale", 32'(out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_err_info_pipe.md
RS_ERR_INFO_PIPE -- requirements
Module: rs_err_info_pipe

Interface
REQ-001 Parameter DATA_SYMS, default 8, number of data symbols in codeword; legal range 2..253; codeword is DATA_SYMS+2 symbols.
REQ-002 Parameter CNT_W, default 16, width of error statistics counters; legal range 4..32.
REQ-003 Derived LOC_W = $clog2(DATA_SYMS+2); not overridable.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  syndrome word present.
REQ-008 in_ready  output  1  block accepts syndrome this cycle.
REQ-009 syndrome_in  input  16  [15:8]=S0 (all-ones H row), [7:0]=S1 (alpha^i H row).
REQ-010 out_valid  output  1  decode result present.
REQ-011 out_ready  input  1  downstream accepts result this cycle.
REQ-012 err_loc_out  output  LOC_W  symbol index 0..DATA_SYMS+1; 0 for NE/DUE.
REQ-013 err_val_out  output  8  error value XOR mask; 0 for NE/DUE.
REQ-014 result_out  output  2  00 NE, 01 CE, 10 DUE; 11 never driven.
REQ-015 cnt_clr  input  1  clears statistics counters.
REQ-016 ce_cnt  output  CNT_W  accepted CE results.
REQ-017 due_cnt  output  CNT_W  accepted DUE results.

Function
REQ-018 GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1, alpha=8'h02; log tables computed combinationally (ROM/case), no multicycle iteration.
REQ-019 Pipeline stage 1 registers S0, S1, zero flags and log(S0), log(S1); stage 2 registers loc = (log(S1)-log(S0)) mod 255 and classification.
REQ-020 Latency exactly 2 cycles from input handshake to out_valid with no backpressure; throughput one word per cycle.
REQ-021 Transfer occurs on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-022 in_ready = !stage1_valid | stage2 can advance; stage2 advances when !out_valid | out_ready; in_ready combinational from out_ready, no combinational path from in_valid.
REQ-023 While out_valid&!out_ready, all outputs hold stable; no word dropped or duplicated.
REQ-024 S0==0 & S1==0: NE, loc 0, value 0.
REQ-025 S0!=0 & S1==0: CE, loc DATA_SYMS (parity P0), value S0.
REQ-026 S0==0 & S1!=0: CE, loc DATA_SYMS+1 (parity P1), value S1.
REQ-027 Both nonzero, loc < DATA_SYMS: CE, loc, value S0.
REQ-028 Both nonzero, loc >= DATA_SYMS: DUE, loc 0, value 0.
REQ-029 Subtraction wrap: log(S1)<log(S0) yields log(S1)-log(S0)+255; result in 0..254.

Reset
REQ-030 rst asserted: stage valids clear, out_valid=0, err_loc_out=0, err_val_out=0, result_out=00, ce_cnt=0, due_cnt=0 on next edge.
REQ-031 in_ready=1 in the first cycle after reset deasserts; in-flight words during reset are discarded, not emitted.
REQ-032 rst has priority over every other input, including cnt_clr and handshakes.

Configuration
REQ-033 Macro RS_ERR_INFO_STATS_EN: defined, counters built; increment by one on output handshake of CE/DUE; saturate at 2^CNT_W-1.
REQ-034 cnt_clr and increment same cycle: counter becomes 0 (clear wins).
REQ-035 Macro undefined: no counter flops; ce_cnt and due_cnt tied 0; cnt_clr ignored; ports unchanged.

Verification
REQ-036 DATA_SYMS=8, syndrome 16'h0108, out_ready=1 -> 2 cycles later CE, loc 3, value 8'h01.
REQ-037 syndrome 16'h5A5A -> CE loc 0 value 8'h5A; 16'h3700 -> CE loc 8 value 8'h37; 16'h0042 -> CE loc 9 value 8'h42; 16'h0000 -> NE.
REQ-038 syndrome 16'h011D (log diff 8 >= DATA_SYMS) -> DUE, loc 0, value 0; due_cnt increments 0->1 (STATS_EN).
REQ-039 Back-to-back 4 words, out_ready low cycles 3-6 -> in_ready drops after pipeline fills, outputs stable, all 4 results emitted in order.
REQ-040 STATS_EN, CNT_W=4: 20 CE handshakes -> ce_cnt saturates 15; cnt_clr during CE handshake -> 0; rst mid-stream -> out_valid 0 next cycle, no stale result.
